symbol_corrector: RTL and testbench
===================================

SYMBOL_CORRECTOR -- requirements
Module: symbol_corrector

Interface
REQ-001 SHALL have parameter width, default 16: lanes per frame.
REQ-002 SHALL have parameter num_of_trellis_patterns, default 4: number of error patterns (N).
REQ-003 SHALL have parameter trellis_pattern_depth, default 4: symbols spanned by a pattern (D).
REQ-004 SHALL have parameter branch_bitwidth, default 2: signed pattern element width.
REQ-005 SHALL have parameter est_err_bitwidth, default 9: residual error width.
REQ-006 SHALL have parameter cnt_bitwidth, default 16: correction counter width.
REQ-007 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  frame present on inputs.
- correction_en  in  1  1 = apply corrections; 0 = pass-through.
- clear_counts  in  1  synchronous counter clear.
- symbols_in  in  [1:0] x width  PAM4 codes 0..3, lane 0 earliest.
- res_errors_in  in  signed est_err_bitwidth x width  residual errors from upstream.
- sd_flags  in  $clog2(2N+1) x width  per-lane flag from error_checker_datapath.
- trellis_patterns  in  signed branch_bitwidth x N x D  error patterns, quasi-static.
- out_valid  out  1  corrected frame present.
- symbols_out  out  [1:0] x width  corrected symbols.
- res_errors_out  out  signed est_err_bitwidth x width  res_errors_in delayed to align with symbols_out.
- num_corrections  out  cnt_bitwidth  saturating count of applied flags.
- num_bad_flags  out  8  saturating count of out-of-range flags.

Function
REQ-008 SHALL decode flag f: 0 = none; 1..N = pattern f-1, sign +1; N+1..2N = pattern f-N-1, sign -1; greater than 2N = bad, treated as 0.
REQ-009 SHALL, for a decoded flag at lane i, add sign*pattern[p][k] to the delta of absolute position i+k, for k=0..D-1.
REQ-010 SHALL sum overlapping deltas in a signed 4-bit accumulator, saturating to -8..+7.
REQ-011 SHALL produce symbols_out[j] = clamp(symbols_in[j] + delta[j], 0, 3).
REQ-012 SHALL carry deltas for positions at or beyond width (at most D-1 of them) in a carry register. The carry SHALL be added at lanes 0..D-2 of the next valid frame.
REQ-013 SHALL register outputs with latency exactly 1 clk: inputs sampled with in_valid=1 at edge n appear at edge n+1 with out_valid=1.
REQ-014 SHALL, when in_valid=0: drive out_valid=0 next cycle, hold symbols_out and res_errors_out, and leave the carry and counters unchanged (bubbles are transparent).
REQ-015 SHALL, when correction_en=0 on a valid frame: force all deltas to 0, pass symbols through unchanged, clear the carry, and not increment num_corrections.
REQ-016 SHALL increment num_corrections by the number of lanes with decoded flag ≠ 0 on each valid, enabled frame, saturating at all-ones.
REQ-017 SHALL increment num_bad_flags by the count of bad flags on each valid frame regardless of correction_en, saturating at 255.
REQ-018 SHALL give clear_counts priority over increments in the same cycle. The counter value SHALL become 0.
REQ-019 SHALL treat trellis_patterns as static while in_valid=1; changes take effect on the next frame.

Reset
REQ-020 SHALL, on rst=1 at a clk edge, clear out_valid, symbols_out, res_errors_out, the carry, num_corrections and num_bad_flags to 0.
REQ-021 SHALL discard a frame sampled in the same cycle as rst and its carry. The first post-reset frame SHALL see zero carry.
REQ-022 SHALL give rst priority over in_valid, clear_counts and correction_en.

Structure
REQ-023 SHALL take the flag width $clog2(2N+1) and the delta width (4) from error_gpack, and the symbol width (2) from the shared constants package.
REQ-024 SHALL place flag decode and delta accumulation (width+D-1 positions) in one combinational sub-module, flag_delta_accumulator. Carry, output registers and counters SHALL live in symbol_corrector.

Verification
REQ-025 Isolated flag: N=4, pattern0={1,-1,0,0}, flag[3]=1, symbols all 1 → out lanes 3,4 = 2,0, others 1; num_corrections=1.
REQ-026 Frame wrap: flag[15]=5 with pattern0={1,1,1,0}, symbols all 2 → lane15=1; next frame lanes 0,1 = 1, lane 2 unchanged.
REQ-027 Bubble: same as REQ-026 but two in_valid=0 cycles between frames → identical corrected output, out_valid low during the bubbles.
REQ-028 Clamp and overlap: flags[0]=1 and [1]=1, pattern0={1,1,0,0}, symbol 3 → lane 1 delta +2, output 3; lane 0 output 3.
REQ-029 Bad flag and clear: flag=15 on 3 lanes → symbols unchanged, num_bad_flags=3; then clear_counts together with a bad flag → 0.
REQ-030 Reset mid-stream: carry pending from a lane-15 flag, rst=1 one cycle → next frame uncorrected at lanes 0..2; all outputs 0 during reset.

Source files
------------

// File: rtl/symbol_corrector_pkg.sv
// symbol_corrector_pkg: shared widths and saturation helpers for the symbol corrector.
package symbol_corrector_pkg;
    localparam int sym_w = 2;
    localparam int delta_w = 4;

    function automatic int flag_w(input int n);
        return $clog2(2 * n + 1);
    endfunction

    function automatic logic [delta_w-1:0] sat_delta(input int v);
        return v > 7 ? 4'd7 : v < -8 ? 4'b1000 : delta_w'(v);
    endfunction

    function automatic logic [sym_w-1:0] clamp_sym(input int v);
        return v < 0 ? 2'd0 : v > 3 ? 2'd3 : sym_w'(v);
    endfunction
endpackage

// File: rtl/symbol_corrector_flag_delta_accumulator.sv
// flag_delta_accumulator: decodes per-lane flags and sums pattern deltas over width+depth-1 positions.
module flag_delta_accumulator
    import symbol_corrector_pkg::*;
#(
    parameter int width = 16,
    parameter int num_patterns = 4,
    parameter int depth = 4,
    parameter int branch_bitwidth = 2
) (
    input  logic                                                   enable,
    input  logic [width-1:0][flag_w(num_patterns)-1:0]             flags,
    input  logic [num_patterns-1:0][depth-1:0][branch_bitwidth-1:0] patterns,
    output logic [width+depth-2:0][delta_w-1:0]                    deltas,
    output logic [$clog2(width+1)-1:0]                             num_applied,
    output logic [$clog2(width+1)-1:0]                             num_bad
);
    localparam int cw = $clog2(width + 1);
    int acc [width+depth-1];

    always_comb begin
        num_applied = '0;
        num_bad = '0;
        for (int p = 0; p < width + depth - 1; p++) acc[p] = 0;
        for (int i = 0; i < width; i++) begin
            if (int'(flags[i]) > 2 * num_patterns) num_bad = num_bad + cw'(1);
            else if (enable && flags[i] != '0) num_applied = num_applied + cw'(1);
            // flags 1..N select a pattern with +1 sign, N+1..2N the same patterns negated
            for (int p = 0; p < num_patterns; p++)
                for (int k = 0; k < depth; k++) begin
                    if (enable && int'(flags[i]) == p + 1)
                        acc[i+k] = acc[i+k] + int'($signed(patterns[p][k]));
                    if (enable && int'(flags[i]) == p + num_patterns + 1)
                        acc[i+k] = acc[i+k] - int'($signed(patterns[p][k]));
                end
        end
        for (int p = 0; p < width + depth - 1; p++) deltas[p] = sat_delta(acc[p]);
    end
endmodule

// File: rtl/symbol_corrector.sv
// symbol_corrector: applies flagged trellis error patterns to PAM4 symbols, carrying
// deltas across frame boundaries, with saturating correction and bad-flag counters.
module symbol_corrector
    import symbol_corrector_pkg::*;
#(
    parameter int width = 16,
    parameter int num_of_trellis_patterns = 4,
    parameter int trellis_pattern_depth = 4,
    parameter int branch_bitwidth = 2,
    parameter int est_err_bitwidth = 9,
    parameter int cnt_bitwidth = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic correction_en,
    input  logic clear_counts,
    input  logic [width-1:0][sym_w-1:0] symbols_in,
    input  logic signed [width-1:0][est_err_bitwidth-1:0] res_errors_in,
    input  logic [width-1:0][flag_w(num_of_trellis_patterns)-1:0] sd_flags,
    input  logic signed [num_of_trellis_patterns-1:0][trellis_pattern_depth-1:0][branch_bitwidth-1:0] trellis_patterns,
    output logic out_valid,
    output logic [width-1:0][sym_w-1:0] symbols_out,
    output logic signed [width-1:0][est_err_bitwidth-1:0] res_errors_out,
    output logic [cnt_bitwidth-1:0] num_corrections,
    output logic [7:0] num_bad_flags
);
    localparam int d = trellis_pattern_depth;
    localparam int cw = $clog2(width + 1);

    logic [width+d-2:0][delta_w-1:0] deltas;
    logic [cw-1:0] num_applied, num_bad;
    logic [d-2:0][delta_w-1:0] carry;
    logic [width-1:0][delta_w-1:0] lane_delta;
    logic [width-1:0][sym_w-1:0] next_symbols;
    logic [cnt_bitwidth:0] corr_sum;
    logic [8:0] bad_sum;

    flag_delta_accumulator #(
        .width(width),
        .num_patterns(num_of_trellis_patterns),
        .depth(d),
        .branch_bitwidth(branch_bitwidth)
    ) u_acc (
        .enable(correction_en),
        .flags(sd_flags),
        .patterns(trellis_patterns),
        .deltas(deltas),
        .num_applied(num_applied),
        .num_bad(num_bad)
    );

    always_comb begin
        lane_delta = deltas[width-1:0];
        if (correction_en)
            for (int j = 0; j < d - 1; j++)
                lane_delta[j] = sat_delta(int'($signed(deltas[j])) + int'($signed(carry[j])));
        for (int j = 0; j < width; j++)
            next_symbols[j] = clamp_sym(int'(symbols_in[j]) + int'($signed(lane_delta[j])));
    end

    assign corr_sum = {1'b0, num_corrections} + (cnt_bitwidth + 1)'(num_applied);
    assign bad_sum = {1'b0, num_bad_flags} + 9'(num_bad);

    // a disabled frame yields all-zero deltas, so it also clears the carry
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            symbols_out <= '0;
            res_errors_out <= '0;
            carry <= '0;
            num_corrections <= '0;
            num_bad_flags <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                symbols_out <= next_symbols;
                res_errors_out <= res_errors_in;
                carry <= deltas[width+d-2:width];
            end
            if (clear_counts) begin
                num_corrections <= '0;
                num_bad_flags <= '0;
            end else if (in_valid) begin
                num_corrections <= corr_sum[cnt_bitwidth] ? '1 : corr_sum[cnt_bitwidth-1:0];
                num_bad_flags <= bad_sum[8] ? 8'hff : bad_sum[7:0];
            end
        end
    end
endmodule

// File: tb/tb_symbol_corrector.sv
// tb_symbol_corrector: table vectors, directed frame-wrap/bubble/reset sequences and a
// randomized run against an arithmetic reference model of the corrector.
module tb_symbol_corrector;
    localparam int W = 16, N = 4, D = 4, BW = 2, EW = 9, CW = 16;
    localparam int FW = $clog2(2 * N + 1);

    typedef logic [W-1:0][1:0] sym_vec_t;
    typedef logic [W-1:0][FW-1:0] flag_vec_t;
    typedef logic [W-1:0][EW-1:0] res_vec_t;

    typedef struct {
        sym_vec_t sym;
        flag_vec_t flg;
        logic en;
        sym_vec_t exp_sym;
        int corr_inc;
        int bad_inc;
    } vec_t;

    logic clk = 1'b0;
    logic rst, in_valid, correction_en, clear_counts;
    sym_vec_t symbols_in, symbols_out;
    res_vec_t res_errors_in, res_errors_out;
    flag_vec_t sd_flags;
    logic [N-1:0][D-1:0][BW-1:0] trellis_patterns;
    logic out_valid;
    logic [CW-1:0] num_corrections;
    logic [7:0] num_bad_flags;

    int pat [N][D];
    int errors = 0, checks = 0;

    logic m_valid;
    sym_vec_t m_sym;
    res_vec_t m_res;
    int m_carry [D-1];
    int m_corr, m_bad;

    always #5 clk = ~clk;

    symbol_corrector dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .correction_en(correction_en),
        .clear_counts(clear_counts), .symbols_in(symbols_in), .res_errors_in(res_errors_in),
        .sd_flags(sd_flags), .trellis_patterns(trellis_patterns), .out_valid(out_valid),
        .symbols_out(symbols_out), .res_errors_out(res_errors_out),
        .num_corrections(num_corrections), .num_bad_flags(num_bad_flags)
    );

    function automatic int clampi(input int v, input int lo, input int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    function automatic sym_vec_t fill(input int s);
        sym_vec_t r;
        for (int j = 0; j < W; j++) r[j] = 2'(s);
        return r;
    endfunction

    function automatic res_vec_t rand_res();
        res_vec_t r;
        for (int j = 0; j < W; j++) r[j] = EW'($urandom);
        return r;
    endfunction

    task automatic load_patterns();
        for (int p = 0; p < N; p++)
            for (int k = 0; k < D; k++) trellis_patterns[p][k] = BW'(pat[p][k]);
    endtask

    // Reference: decode each flag, sum signed pattern contributions per absolute position,
    // saturate to 4 bits, fold in the previous frame's spill, clamp the symbol to 0..3.
    task automatic model_step();
        int acc [W+D-1];
        int f, d, na, nb;
        na = 0;
        nb = 0;
        if (rst) begin
            m_valid = 1'b0;
            m_sym = '0;
            m_res = '0;
            for (int m = 0; m < D - 1; m++) m_carry[m] = 0;
            m_corr = 0;
            m_bad = 0;
            return;
        end
        m_valid = in_valid;
        if (in_valid) begin
            for (int p = 0; p < W + D - 1; p++) acc[p] = 0;
            for (int i = 0; i < W; i++) begin
                f = int'(sd_flags[i]);
                if (f > 2 * N) nb++;
                else if (f > 0 && correction_en) begin
                    na++;
                    for (int k = 0; k < D; k++) acc[i+k] += f <= N ? pat[f-1][k] : -pat[f-N-1][k];
                end
            end
            for (int j = 0; j < W; j++) begin
                d = clampi(acc[j], -8, 7);
                if (correction_en && j < D - 1) d = clampi(d + m_carry[j], -8, 7);
                m_sym[j] = 2'(clampi(int'(symbols_in[j]) + d, 0, 3));
            end
            for (int m = 0; m < D - 1; m++) m_carry[m] = clampi(acc[W+m], -8, 7);
            m_res = res_errors_in;
        end
        if (clear_counts) begin
            m_corr = 0;
            m_bad = 0;
        end else if (in_valid) begin
            m_corr = m_corr + na > 65535 ? 65535 : m_corr + na;
            m_bad = m_bad + nb > 255 ? 255 : m_bad + nb;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 256'(out_valid), 256'(m_valid));
        chk({tag, ".sym"}, 256'(symbols_out), 256'(m_sym));
        chk({tag, ".res"}, 256'(res_errors_out), 256'(m_res));
        chk({tag, ".corr"}, 256'(num_corrections), 256'(m_corr));
        chk({tag, ".bad"}, 256'(num_bad_flags), 256'(m_bad));
    endtask

    task automatic idle();
        rst = 1'b0;
        in_valid = 1'b0;
        correction_en = 1'b1;
        clear_counts = 1'b0;
        sd_flags = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        in_valid = 1'b1;
        symbols_in = fill(3);
        sd_flags = '0;
        sd_flags[0] = 4'd15;
        res_errors_in = rand_res();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic frame(input sym_vec_t s, input flag_vec_t f);
        in_valid = 1'b1;
        symbols_in = s;
        sd_flags = f;
        res_errors_in = rand_res();
        step();
        in_valid = 1'b0;
    endtask

    vec_t vecs [6];
    sym_vec_t e;
    flag_vec_t fl;
    res_vec_t r;
    int exp_corr, exp_bad;

    initial begin
        idle();
        symbols_in = '0;
        res_errors_in = '0;
        for (int p = 0; p < N; p++) for (int k = 0; k < D; k++) pat[p][k] = 0;
        pat[0][0] = 1; pat[0][1] = -1;
        pat[1][0] = 1; pat[1][1] = 1;
        load_patterns();

        do_reset();
        chk("reset.valid", 256'(out_valid), 256'(0));
        chk("reset.sym", 256'(symbols_out), 256'(0));
        chk("reset.res", 256'(res_errors_out), 256'(0));
        chk("reset.counts", 256'({num_corrections, num_bad_flags}), 256'(0));

        foreach (vecs[v]) begin
            vecs[v].flg = '0;
            vecs[v].en = 1'b1;
            vecs[v].corr_inc = 0;
            vecs[v].bad_inc = 0;
        end
        vecs[0].sym = fill(1); vecs[0].flg[3] = 4'd1;
        vecs[0].exp_sym = fill(1); vecs[0].exp_sym[3] = 2'd2; vecs[0].exp_sym[4] = 2'd0;
        vecs[0].corr_inc = 1;
        vecs[1].sym = fill(3); vecs[1].flg[0] = 4'd2; vecs[1].flg[1] = 4'd2;
        vecs[1].exp_sym = fill(3); vecs[1].corr_inc = 2;
        vecs[2].sym = fill(1); vecs[2].flg[5] = 4'd6; vecs[2].flg[6] = 4'd6; vecs[2].flg[10] = 4'd5;
        vecs[2].exp_sym = fill(1);
        vecs[2].exp_sym[5] = 2'd0; vecs[2].exp_sym[6] = 2'd0; vecs[2].exp_sym[7] = 2'd0;
        vecs[2].exp_sym[10] = 2'd0; vecs[2].exp_sym[11] = 2'd2;
        vecs[2].corr_inc = 3;
        vecs[3].sym = fill(2); vecs[3].flg[0] = 4'd15; vecs[3].flg[7] = 4'd15; vecs[3].flg[12] = 4'd15;
        vecs[3].exp_sym = fill(2); vecs[3].bad_inc = 3;
        vecs[4].sym = fill(1); vecs[4].flg[3] = 4'd1; vecs[4].flg[4] = 4'd15; vecs[4].en = 1'b0;
        vecs[4].exp_sym = fill(1); vecs[4].bad_inc = 1;
        for (int j = 0; j < W; j++) vecs[5].sym[j] = 2'(j % 4);
        vecs[5].flg[8] = 4'd1; vecs[5].flg[2] = 4'd3;
        vecs[5].exp_sym = vecs[5].sym; vecs[5].exp_sym[8] = 2'd1; vecs[5].exp_sym[9] = 2'd0;
        vecs[5].corr_inc = 2;

        exp_corr = 0;
        exp_bad = 0;
        foreach (vecs[v]) begin
            correction_en = vecs[v].en;
            frame(vecs[v].sym, vecs[v].flg);
            r = res_errors_in;
            exp_corr += vecs[v].corr_inc;
            exp_bad += vecs[v].bad_inc;
            chk($sformatf("vec%0d.valid", v), 256'(out_valid), 256'(1));
            chk($sformatf("vec%0d.sym", v), 256'(symbols_out), 256'(vecs[v].exp_sym));
            chk($sformatf("vec%0d.res", v), 256'(res_errors_out), 256'(r));
            chk($sformatf("vec%0d.corr", v), 256'(num_corrections), 256'(exp_corr));
            chk($sformatf("vec%0d.bad", v), 256'(num_bad_flags), 256'(exp_bad));
        end
        correction_en = 1'b1;

        fl = '0;
        fl[0] = 4'd15;
        clear_counts = 1'b1;
        frame(fill(0), fl);
        clear_counts = 1'b0;
        chk("clear.counts", 256'({num_corrections, num_bad_flags}), 256'(0));
        frame(fill(0), fl);
        chk("after_clear.bad", 256'(num_bad_flags), 256'(1));

        pat[0][0] = 1; pat[0][1] = 1; pat[0][2] = 1; pat[0][3] = 0;
        load_patterns();
        for (int mode = 0; mode < 3; mode++) begin
            do_reset();
            fl = '0;
            fl[15] = 4'd5;
            frame(fill(2), fl);
            e = fill(2);
            e[15] = 2'd1;
            chk($sformatf("wrap%0d.first", mode), 256'(symbols_out), 256'(e));
            if (mode == 1)
                for (int b = 0; b < 2; b++) begin
                    step();
                    chk($sformatf("bubble%0d.valid", b), 256'(out_valid), 256'(0));
                    chk($sformatf("bubble%0d.hold", b), 256'(symbols_out), 256'(e));
                end
            if (mode == 2) begin
                rst = 1'b1;
                fl = '0;
                fl[0] = 4'd15;
                frame(fill(3), fl);
                rst = 1'b0;
                chk("midreset.valid", 256'(out_valid), 256'(0));
                chk("midreset.sym", 256'(symbols_out), 256'(0));
                chk("midreset.counts", 256'({num_corrections, num_bad_flags}), 256'(0));
            end
            frame(fill(2), '0);
            e = fill(2);
            if (mode != 2) begin
                e[0] = 2'd1;
                e[1] = 2'd1;
            end
            chk($sformatf("wrap%0d.second", mode), 256'(symbols_out), 256'(e));
            chk($sformatf("wrap%0d.valid", mode), 256'(out_valid), 256'(1));
        end

        for (int p = 0; p < N; p++)
            for (int k = 0; k < D; k++) pat[p][k] = int'($urandom_range(0, 3)) - 2;
        load_patterns();
        do_reset();
        chk_model("rnd_reset");
        for (int c = 0; c < 400; c++) begin
            rst = $urandom_range(0, 99) < 2;
            in_valid = $urandom_range(0, 99) < 80;
            correction_en = $urandom_range(0, 99) < 85;
            clear_counts = $urandom_range(0, 99) < 2;
            for (int j = 0; j < W; j++) begin
                symbols_in[j] = 2'($urandom);
                sd_flags[j] = $urandom_range(0, 9) < 6 ? '0 : FW'($urandom);
            end
            res_errors_in = rand_res();
            if (!in_valid && $urandom_range(0, 99) < 10) begin
                for (int p = 0; p < N; p++)
                    for (int k = 0; k < D; k++) pat[p][k] = int'($urandom_range(0, 3)) - 2;
                load_patterns();
            end
            step();
            chk_model($sformatf("rnd%0d", c));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
